// File: rtl/traffic_light_monitor.sv
// Passive checker for the red/yellow/green lamp interface: one-hot, phase
// order RED->GREEN->YELLOW->RED and exact phase lengths.
// Ports: clk, reset (sync, active-high), red/yellow/green lamp inputs;
// cur_phase (00 none, 01 RED, 10 YELLOW, 11 GREEN), phase_len,
// err_onehot/err_order/err_short/err_long pulses, sticky fault and
// cycles_done (legal RED->GREEN count). All outputs registered.
// Optional macro TLC_MON_RECOVER_EN: FAULT relocks on a one-hot sample.
module traffic_light_monitor #(
  parameter int RED_CYCLES    = 5,
  parameter int GREEN_CYCLES  = 4,
  parameter int YELLOW_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  output logic [1:0]       cur_phase,
  output logic [CNT_W-1:0] phase_len,
  output logic             err_onehot,
  output logic             err_order,
  output logic             err_short,
  output logic             err_long,
  output logic             fault,
  output logic [CNT_W-1:0] cycles_done
);

  typedef enum logic [2:0] {
    SYNC,
    CHK_RED,
    CHK_GREEN,
    CHK_YELLOW,
    FAULT
  } state_t;

  localparam logic [CNT_W-1:0] RED_LEN = CNT_W'(RED_CYCLES);
  localparam logic [CNT_W-1:0] GRN_LEN = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] YEL_LEN = CNT_W'(YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX     = '1;

  state_t           state;
  logic             partial;

  logic             onehot;
  logic [1:0]       smp_phase;
  state_t           smp_state;
  logic [CNT_W-1:0] req;
  state_t           succ;

  // Decode the sampled lamps into a phase.
  always_comb begin
    onehot    = 1'b1;
    smp_phase = 2'b00;
    smp_state = SYNC;
    case ({red, yellow, green})
      3'b100: begin
        smp_phase = 2'b01;
        smp_state = CHK_RED;
      end
      3'b010: begin
        smp_phase = 2'b10;
        smp_state = CHK_YELLOW;
      end
      3'b001: begin
        smp_phase = 2'b11;
        smp_state = CHK_GREEN;
      end
      default: onehot = 1'b0;
    endcase
  end

  // Required length and legal successor of the phase being checked.
  always_comb begin
    req  = MAX;
    succ = SYNC;
    case (state)
      CHK_RED: begin
        req  = RED_LEN;
        succ = CHK_GREEN;
      end
      CHK_GREEN: begin
        req  = GRN_LEN;
        succ = CHK_YELLOW;
      end
      CHK_YELLOW: begin
        req  = YEL_LEN;
        succ = CHK_RED;
      end
      default: begin
        req  = MAX;
        succ = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SYNC;
      partial     <= 1'b0;
      cur_phase   <= 2'b00;
      phase_len   <= '0;
      err_onehot  <= 1'b0;
      err_order   <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      fault       <= 1'b0;
      cycles_done <= '0;
    end else begin
      err_onehot <= 1'b0;
      err_order  <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      case (state)
        SYNC: begin
          if (!onehot) begin
            err_onehot <= 1'b1;
            fault      <= 1'b1;
            cur_phase  <= 2'b00;
            state      <= FAULT;
          end else begin
            state     <= smp_state;
            cur_phase <= smp_phase;
            phase_len <= ONE;
            partial   <= 1'b1;
          end
        end
        FAULT: begin
          cur_phase <= 2'b00;
`ifdef TLC_MON_RECOVER_EN
          // Relock exactly like a fresh SYNC entry.
          if (onehot) begin
            state     <= smp_state;
            cur_phase <= smp_phase;
            phase_len <= ONE;
            partial   <= 1'b1;
          end
`endif
        end
        default: begin
          // Error priority: onehot > order > short; long is exclusive.
          if (!onehot) begin
            err_onehot <= 1'b1;
            fault      <= 1'b1;
            cur_phase  <= 2'b00;
            state      <= FAULT;
          end else if (smp_state == state) begin
            if (!partial && phase_len == req) begin
              err_long  <= 1'b1;
              fault     <= 1'b1;
              cur_phase <= 2'b00;
              state     <= FAULT;
            end else if (phase_len != MAX) begin
              phase_len <= phase_len + ONE;
            end
          end else if (smp_state != succ) begin
            err_order <= 1'b1;
            fault     <= 1'b1;
            cur_phase <= 2'b00;
            state     <= FAULT;
          end else if (!partial && phase_len < req) begin
            err_short <= 1'b1;
            fault     <= 1'b1;
            cur_phase <= 2'b00;
            state     <= FAULT;
          end else begin
            state     <= smp_state;
            cur_phase <= smp_phase;
            phase_len <= ONE;
            partial   <= 1'b0;
            if (state == CHK_RED)
              cycles_done <= cycles_done + ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus
// randomized lamp streams compared against a phase-rule reference model.
module tb_traffic_light_monitor;

  localparam int RC = 5;
  localparam int GC = 4;
  localparam int YC = 2;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          red = 1'b0;
  logic          yellow = 1'b0;
  logic          green = 1'b0;
  logic [1:0]    cur_phase;
  logic [CW-1:0] phase_len;
  logic          err_onehot;
  logic          err_order;
  logic          err_short;
  logic          err_long;
  logic          fault;
  logic [CW-1:0] cycles_done;

  int checks = 0;
  int fails  = 0;

  traffic_light_monitor #(
    .RED_CYCLES   (RC),
    .GREEN_CYCLES (GC),
    .YELLOW_CYCLES(YC),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .cur_phase  (cur_phase),
    .phase_len  (phase_len),
    .err_onehot (err_onehot),
    .err_order  (err_order),
    .err_short  (err_short),
    .err_long   (err_long),
    .fault      (fault),
    .cycles_done(cycles_done)
  );

  always #5 clk = ~clk;

  // Reference model. Phase codes: 0 none, 1 RED, 2 YELLOW, 3 GREEN.
  // mode: 0 waiting to lock, 1 checking, 2 faulted.
  int m_mode, m_ph, m_len, m_cyc;
  bit m_part, m_flt, m_eoh, m_eord, m_esh, m_elg;

  int req_of [4] = '{0, RC, YC, GC};
  int next_of[4] = '{0, 3, 1, 2};

  function automatic int code_of(input bit r, input bit y, input bit g);
    if (int'(r) + int'(y) + int'(g) != 1) return 0;
    if (r) return 1;
    if (y) return 2;
    return 3;
  endfunction

  task automatic model(input bit rst, input bit r, input bit y,
                       input bit g);
    int c;
    bit relock;
    c = code_of(r, y, g);
    {m_eoh, m_eord, m_esh, m_elg} = '0;
    if (rst) begin
      m_mode = 0; m_ph = 0; m_len = 0; m_cyc = 0;
      m_part = 0; m_flt = 0;
      return;
    end
    relock = 0;
`ifdef TLC_MON_RECOVER_EN
    relock = (m_mode == 2) && (c != 0);
`endif
    if (m_mode == 0 || relock) begin
      if (c == 0) begin
        m_eoh = 1; m_mode = 2;
      end else begin
        m_mode = 1; m_ph = c; m_len = 1; m_part = 1;
      end
    end else if (m_mode == 1) begin
      if (c == 0) m_eoh = 1;
      else if (c == m_ph) begin
        if (!m_part && m_len == req_of[m_ph]) m_elg = 1;
        else if (m_len < CMAX) m_len++;
      end else if (c != next_of[m_ph]) m_eord = 1;
      else if (!m_part && m_len < req_of[m_ph]) m_esh = 1;
      else begin
        if (m_ph == 1) m_cyc = (m_cyc + 1) % (CMAX + 1);
        m_ph = c; m_len = 1; m_part = 0;
      end
      if (m_eoh || m_eord || m_esh || m_elg) m_mode = 2;
    end
    if (m_eoh || m_eord || m_esh || m_elg) m_flt = 1;
    if (m_mode != 1) m_ph = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit y, input bit g,
                      input bit rst = 1'b0);
    red = r; yellow = y; green = g; reset = rst;
    @(posedge clk);
    model(rst, r, y, g);
    #1;
    chk("cur_phase", 32'(cur_phase), 32'(m_ph));
    chk("phase_len", 32'(phase_len), 32'(m_len));
    chk("err_onehot", 32'(err_onehot), 32'(m_eoh));
    chk("err_order", 32'(err_order), 32'(m_eord));
    chk("err_short", 32'(err_short), 32'(m_esh));
    chk("err_long", 32'(err_long), 32'(m_elg));
    chk("fault", 32'(fault), 32'(m_flt));
    chk("cycles_done", 32'(cycles_done), 32'(m_cyc));
  endtask

  task automatic lamp(input int c, input int n);
    repeat (n) step(c == 1, c == 2, c == 3);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int c, len, k;

    // Clean cycles after reset.
    do_reset(2);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_phase", 32'(cur_phase), 32'd0);
    repeat (3) begin
      lamp(1, RC); lamp(3, GC); lamp(2, YC);
    end
    chk("clean_cyc", 32'(cycles_done), 32'd3);
    chk("clean_fault", 32'(fault), 32'd0);
    chk("clean_phase", 32'(cur_phase), 32'd2);

    // GREEN held one cycle too long.
    lamp(1, RC); lamp(3, GC + 1);
    chk("long_pulse", 32'(err_long), 32'd1);
    chk("long_fault", 32'(fault), 32'd1);
    chk("long_phase", 32'(cur_phase), 32'd0);
    lamp(3, 2);
    chk("long_once", 32'(err_long), 32'd0);

    // RED then YELLOW is out of order.
    do_reset(1);
    lamp(1, RC); lamp(3, GC); lamp(2, YC); lamp(1, RC); lamp(2, 1);
    chk("order_pulse", 32'(err_order), 32'd1);
    chk("order_cyc", 32'(cycles_done), 32'd1);

    // Partial GREEN accepted, short YELLOW flagged.
    do_reset(1);
    lamp(3, 2); lamp(2, 1); lamp(1, 1);
    chk("short_pulse", 32'(err_short), 32'd1);

    // Two lamps mid-RED: only err_onehot.
    do_reset(1);
    lamp(1, 3);
    step(1'b1, 1'b0, 1'b1);
    chk("oh_pulse", 32'(err_onehot), 32'd1);
    chk("oh_noorder", 32'(err_order), 32'd0);
    lamp(1, 3); lamp(2, 1); lamp(1, 2);

    // Reset mid-GREEN, then relock cleanly.
    do_reset(1);
    lamp(1, RC); lamp(3, 3);
    chk("mid_len", 32'(phase_len), 32'd3);
    do_reset(1);
    chk("mid_rst_len", 32'(phase_len), 32'd0);
    chk("mid_rst_cyc", 32'(cycles_done), 32'd0);
    lamp(2, 1); lamp(1, RC); lamp(3, GC);
    chk("relock_fault", 32'(fault), 32'd0);

    // Partial RED saturates, then still advances legally.
    do_reset(1);
    lamp(1, CMAX + 20);
    chk("sat_len", 32'(phase_len), 32'(CMAX));
    lamp(3, GC);
    chk("sat_cyc", 32'(cycles_done), 32'd1);

    // Randomized streams of mostly-legal phases with perturbations.
    for (int blk = 0; blk < 16; blk++) begin
      do_reset(1 + $urandom_range(0, 1));
      c = 1 + $urandom_range(0, 2);
      for (int p = 0; p < 14; p++) begin
        len = req_of[c];
        k = $urandom_range(0, 11);
        if (k == 0) len = len + 1;
        else if (k == 1 && len > 1) len = len - 1;
        if ($urandom_range(0, 14) == 0)
          step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1);
        lamp(c, len);
        if ($urandom_range(0, 19) == 0) c = 1 + $urandom_range(0, 2);
        else c = next_of[c];
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
